switch_pulse_gen: RTL

SWITCH_PULSE_GEN -- requirements
Module: switch_pulse_gen

---
 rtl/switch_pulse_gen_if.sv | 25 ++
 rtl/switch_pulse_gen.sv | 132 +++++++++++++
 2 files changed

// File: rtl/switch_pulse_gen_if.sv
// Switch-side signal bundle for switch_pulse_gen: raw button in, debounced level and strobes out.
// The slave modport is the generator's view; the master modport is the view of whoever drives the button.
interface switch_pulse_gen_if;
   logic i_Switch;
   logic o_Switch;
   logic o_Press_Pulse;
   logic o_Release_Pulse;
   logic o_Step_Pulse;

   modport slave (
      input  i_Switch,
      output o_Switch,
      output o_Press_Pulse,
      output o_Release_Pulse,
      output o_Step_Pulse
   );

   modport master (
      output i_Switch,
      input  o_Switch,
      input  o_Press_Pulse,
      input  o_Release_Pulse,
      input  o_Step_Pulse
   );
endinterface

// File: rtl/switch_pulse_gen.sv
// Push-button conditioner: 2-flop synchronizer, debouncer, press/release/step strobes.
// Define SWITCH_AUTO_REPEAT_EN to build in the hold-to-repeat FSM that adds extra step pulses.
module switch_pulse_gen #(
   parameter int DEBOUNCE_LIMIT = 250000,
   parameter int REPEAT_DELAY   = 12500000,
   parameter int REPEAT_PERIOD  = 2500000
) (
   input logic              i_Clk,
   input logic              i_Rst_L,
   switch_pulse_gen_if.slave io_Sw
);

   localparam int DB_W = $clog2(DEBOUNCE_LIMIT + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);

   if (DEBOUNCE_LIMIT < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
      $error("switch_pulse_gen: DEBOUNCE_LIMIT, REPEAT_DELAY and REPEAT_PERIOD must all be 2 or more");
   end

   logic            r_Sync1;
   logic            r_Sync2;
   logic            r_Switch;
   logic            r_Press;
   logic            r_Release;
   logic            r_Step;
   logic [DB_W-1:0] r_Db_Count;

   logic w_Differ;
   logic w_Toggle;
   logic w_Switch_Next;
   logic w_Press_Next;
   logic w_Release_Next;
   logic w_Repeat;

   // All strobes are decided at the same edge that flips the debounced level, so they line up with it.
   assign w_Differ       = (r_Sync2 != r_Switch);
   assign w_Toggle       = w_Differ && (r_Db_Count == DB_LAST);
   assign w_Switch_Next  = r_Switch ^ w_Toggle;
   assign w_Press_Next   = w_Toggle && !r_Switch;
   assign w_Release_Next = w_Toggle && r_Switch;

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         r_Sync1    <= 1'b0;
         r_Sync2    <= 1'b0;
         r_Switch   <= 1'b0;
         r_Press    <= 1'b0;
         r_Release  <= 1'b0;
         r_Step     <= 1'b0;
         r_Db_Count <= '0;
      end else begin
         r_Sync1   <= io_Sw.i_Switch;
         r_Sync2   <= r_Sync1;
         r_Switch  <= w_Switch_Next;
         r_Press   <= w_Press_Next;
         r_Release <= w_Release_Next;
         r_Step    <= w_Press_Next || w_Repeat;
         if (!w_Differ || w_Toggle) begin
            r_Db_Count <= '0;
         end else begin
            r_Db_Count <= r_Db_Count + 1'b1;
         end
      end
   end

`ifdef SWITCH_AUTO_REPEAT_EN
   localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } repeat_state_t;

   repeat_state_t    r_State;
   repeat_state_t    w_State_Next;
   logic [TMR_W-1:0] r_Timer;
   logic [TMR_W-1:0] w_Timer_Next;

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         r_State <= IDLE;
         r_Timer <= '0;
      end else begin
         r_State <= w_State_Next;
         r_Timer <= w_Timer_Next;
      end
   end

   // The timer counts down to zero; reloading on the pulse edge keeps repeats drift-free.
   // DELAY loads two short because the load edge is already one cycle past the press pulse.
   // Checking w_Switch_Next first lets a release beat a repeat falling due on the same edge.
   always_comb begin
      w_State_Next = r_State;
      w_Timer_Next = r_Timer;
      w_Repeat     = 1'b0;
      case (r_State)
         IDLE: begin
            if (r_Press) begin
               w_State_Next = DELAY;
               w_Timer_Next = TMR_W'(REPEAT_DELAY - 2);
            end
         end
         DELAY, REPEAT: begin
            if (!w_Switch_Next) begin
               w_State_Next = IDLE;
               w_Timer_Next = '0;
            end else if (r_Timer == '0) begin
               w_State_Next = REPEAT;
               w_Timer_Next = TMR_W'(REPEAT_PERIOD - 1);
               w_Repeat     = 1'b1;
            end else begin
               w_Timer_Next = r_Timer - 1'b1;
            end
         end
         default: begin
            w_State_Next = IDLE;
            w_Timer_Next = '0;
         end
      endcase
   end
`else
   assign w_Repeat = 1'b0;
`endif

   assign io_Sw.o_Switch        = r_Switch;
   assign io_Sw.o_Press_Pulse   = r_Press;
   assign io_Sw.o_Release_Pulse = r_Release;
   assign io_Sw.o_Step_Pulse    = r_Step;

endmodule
